// File: rtl/rede_taylor_core.sv
// Taylor-network neuron: requests N_IN samples, accumulates bias + weighted inputs, emits clamped s - s^3/3.
// Latency: first result N_IN+4 edges after reset release, then one result every N_IN+4 cycles.
// Backpressure: none; io_in is sampled on a fixed schedule announced by req_in, out_en strobes one cycle.
module rede_taylor_core #(
    parameter int                 N_IN  = 3,
    parameter int                 FRAC  = 8,
    parameter logic signed [18:0] W0    = 19'sd256,
    parameter logic signed [18:0] W1    = 19'sd256,
    parameter logic signed [18:0] W2    = 19'sd256,
    parameter logic signed [18:0] W3    = 19'sd256,
    parameter logic signed [18:0] W4    = 19'sd256,
    parameter logic signed [18:0] W5    = 19'sd256,
    parameter logic signed [18:0] W6    = 19'sd256,
    parameter logic signed [18:0] W7    = 19'sd256,
    parameter logic signed [18:0] W8    = 19'sd256,
    parameter logic signed [18:0] W9    = 19'sd256,
    parameter logic signed [18:0] W10   = 19'sd256,
    parameter logic signed [18:0] W11   = 19'sd256,
    parameter logic signed [18:0] W12   = 19'sd256,
    parameter logic signed [18:0] W13   = 19'sd256,
    parameter logic signed [27:0] BIAS  = 28'sd0,
    parameter logic signed [18:0] C3    = -19'sd85,
    parameter int                 CLAMP = 256
) (
    input  logic               clk,
    input  logic               rst,
    input  logic signed [18:0] io_in,
    output logic signed [27:0] io_out,
    output logic        [3:0]  req_in,
    output logic        [3:0]  out_en
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READ,
        ST_CLAMP,
        ST_SQ,
        ST_CUBE,
        ST_OUT
    } state_t;

    localparam logic signed [39:0] BIAS_EXT = 40'(BIAS);
    localparam logic signed [39:0] CLAMP_HI = 40'(CLAMP);
    localparam logic signed [39:0] CLAMP_LO = -40'(CLAMP);

    state_t             state;
    logic        [3:0]  k;
    logic signed [39:0] acc;
    logic signed [27:0] s;
    logic signed [27:0] s2;

    logic signed [18:0] w_k;
    logic signed [37:0] mac_prod;
    logic signed [39:0] mac_term;
    logic signed [55:0] sq_prod;
    logic signed [55:0] cube_prod;
    logic signed [27:0] s3_nxt;
    logic signed [46:0] corr_prod;
    logic signed [27:0] y_nxt;

    function automatic logic signed [18:0] w_sel(input logic [3:0] idx);
        case (idx)
            4'd0:    return W0;
            4'd1:    return W1;
            4'd2:    return W2;
            4'd3:    return W3;
            4'd4:    return W4;
            4'd5:    return W5;
            4'd6:    return W6;
            4'd7:    return W7;
            4'd8:    return W8;
            4'd9:    return W9;
            4'd10:   return W10;
            4'd11:   return W11;
            4'd12:   return W12;
            4'd13:   return W13;
            default: return 19'sd0;
        endcase
    endfunction

    // Full-precision products; arithmetic shifts floor toward minus infinity.
    assign w_k       = w_sel(k);
    assign mac_prod  = 38'(w_k) * 38'(io_in);
    assign mac_term  = 40'(mac_prod >>> FRAC);
    assign sq_prod   = 56'(s) * 56'(s);
    assign cube_prod = 56'(s2) * 56'(s);
    assign s3_nxt    = 28'(cube_prod >>> FRAC);
    assign corr_prod = 47'(C3) * 47'(s3_nxt);
    assign y_nxt     = s + 28'(corr_prod >>> FRAC);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= ST_IDLE;
            k      <= 4'd0;
            acc    <= BIAS_EXT;
            s      <= 28'sd0;
            s2     <= 28'sd0;
            io_out <= 28'sd0;
            req_in <= 4'd0;
            out_en <= 4'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    state  <= ST_READ;
                    k      <= 4'd0;
                    acc    <= BIAS_EXT;
                    req_in <= 4'd1;
                end
                ST_READ: begin
                    acc <= acc + mac_term;
                    if (k == 4'(N_IN - 1)) begin
                        req_in <= 4'd0;
                        state  <= ST_CLAMP;
                    end else begin
                        k      <= k + 4'd1;
                        req_in <= k + 4'd2;
                    end
                end
                ST_CLAMP: begin
                    if (acc > CLAMP_HI)
                        s <= 28'(CLAMP_HI);
                    else if (acc < CLAMP_LO)
                        s <= 28'(CLAMP_LO);
                    else
                        s <= 28'(acc);
                    state <= ST_SQ;
                end
                ST_SQ: begin
                    s2    <= 28'(sq_prod >>> FRAC);
                    state <= ST_CUBE;
                end
                // Cube and correction resolve in the same cycle so the frame stays N_IN+4 long.
                ST_CUBE: begin
                    io_out <= y_nxt;
                    out_en <= 4'd1;
                    state  <= ST_OUT;
                end
                ST_OUT: begin
                    out_en <= 4'd0;
                    acc    <= BIAS_EXT;
                    k      <= 4'd0;
                    req_in <= 4'd1;
                    state  <= ST_READ;
                end
                default: begin
                    state  <= ST_IDLE;
                    req_in <= 4'd0;
                    out_en <= 4'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rede_taylor_core.sv
// Bench for rede_taylor_core: frame-level model plus hand-computed checkpoints, default and biased instances.
module tb_rede_taylor_core;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               rst;
    logic signed [18:0] io_in;
    logic signed [27:0] io_out, io_out_b;
    logic        [3:0]  req_in, req_in_b, out_en, out_en_b;

    int     n_chk  = 0;
    int     n_fail = 0;
    int     c;
    int     frame_base;
    longint exp_out, exp_out_b;

    int frames [0:11][0:2] = '{
        '{64, 64, 0}, '{256, 256, 256}, '{-256, -256, -256}, '{0, 0, 0},
        '{100, -30, 7}, '{-1, 0, 0}, '{256, 256, 0}, '{64, 64, 0},
        '{300, -5, -600}, '{-50, 20, 1}, '{0, 0, 0}, '{0, 0, 0}
    };

    rede_taylor_core dut (
        .clk(clk), .rst(rst), .io_in(io_in),
        .io_out(io_out), .req_in(req_in), .out_en(out_en)
    );

    rede_taylor_core #(.BIAS(28'sd128)) dut_b (
        .clk(clk), .rst(rst), .io_in(io_in),
        .io_out(io_out_b), .req_in(req_in_b), .out_en(out_en_b)
    );

    task automatic chk(input string name, input longint act, input longint exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int fidx();
        int f;
        f = frame_base + (c > 0 ? (c - 1) / 7 : 0);
        return (f > 11) ? 11 : f;
    endfunction

    // Frame result straight from the arithmetic definition: weights 256, clamp +-1.0, y = s + C3*s^3.
    function automatic longint model(input longint bias, input int fi);
        longint acc, s, s2, s3;
        acc = bias;
        for (int i = 0; i < 3; i++)
            acc += (longint'(256) * longint'(frames[fi][i])) >>> 8;
        s  = (acc > 256) ? 256 : ((acc < -256) ? -256 : acc);
        s2 = (s * s) >>> 8;
        s3 = (s2 * s) >>> 8;
        return s + ((longint'(-85) * s3) >>> 8);
    endfunction

    // Cycles since reset release; the schedule is a pure function of this count.
    always @(posedge clk or negedge rst) begin
        if (!rst) c <= 0;
        else      c <= c + 1;
    end

    // Environment: answer the scheduled request, otherwise drive junk that must be ignored.
    initial begin
        io_in = 19'h2A5A5;
        forever begin
            @(posedge clk);
            #1;
            if (rst && c > 0 && ((c - 1) % 7) < 3)
                io_in = 19'(frames[fidx()][(c - 1) % 7]);
            else
                io_in = 19'h2A5A5;
        end
    end

    always @(negedge clk) begin
        longint exp_req, exp_en;
        if (!rst) begin
            exp_out   = 0;
            exp_out_b = 0;
            chk("rst_req_in", req_in, 0);
            chk("rst_out_en", out_en, 0);
            chk("rst_io_out", io_out, 0);
            chk("rst_io_out_b", io_out_b, 0);
        end else begin
            exp_req = (c > 0 && ((c - 1) % 7) < 3) ? longint'((c - 1) % 7 + 1) : 0;
            exp_en  = (c > 0 && ((c - 1) % 7) == 6) ? 1 : 0;
            if (exp_en == 1) begin
                exp_out   = model(0, fidx());
                exp_out_b = model(128, fidx());
            end
            chk("model_req_in", req_in, exp_req);
            chk("model_out_en", out_en, exp_en);
            chk("model_io_out", io_out, exp_out);
            chk("model_req_in_b", req_in_b, exp_req);
            chk("model_out_en_b", out_en_b, exp_en);
            chk("model_io_out_b", io_out_b, exp_out_b);
        end
    end

    initial begin
        rst        = 1'b0;
        frame_base = 0;
        repeat (3) @(negedge clk);
        chk("reset_io_out", io_out, 0);
        chk("reset_req_in", req_in, 0);
        chk("reset_out_en", out_en, 0);
        rst = 1'b1;

        @(negedge clk); chk("start_req1", req_in, 1);
        @(negedge clk); chk("start_req2", req_in, 2);
        @(negedge clk); chk("start_req3", req_in, 3);
        @(negedge clk); chk("start_req0", req_in, 0);
        repeat (3) @(negedge clk);
        chk("small_out_en", out_en, 1);
        chk("small_io_out", io_out, 117);
        chk("bias_small_io_out", io_out_b, 171);
        @(negedge clk); chk("strobe_one_cycle", out_en, 0);
        repeat (6) @(negedge clk);
        chk("pos_clamp_io_out", io_out, 171);
        chk("pos_clamp_out_en", out_en, 1);
        repeat (7) @(negedge clk);
        chk("neg_clamp_io_out", io_out, -171);
        repeat (7) @(negedge clk);
        chk("zero_io_out", io_out, 0);
        chk("zero_bias_io_out", io_out_b, 117);
        repeat (14) @(negedge clk);
        chk("minus_one_io_out", io_out, -1);

        repeat (2) @(negedge clk);
        chk("midframe_req2", req_in, 2);
        #2 rst = 1'b0;
        #1;
        chk("async_rst_io_out", io_out, 0);
        chk("async_rst_req_in", req_in, 0);
        chk("async_rst_out_en", out_en, 0);
        chk("async_rst_io_out_b", io_out_b, 0);
        frame_base = 7;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (7) @(negedge clk);
        chk("post_reset_io_out", io_out, 117);
        chk("post_reset_out_en", out_en, 1);
        repeat (15) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/rede_taylor_core.md
Name: rede_taylor_core

Overview:
- One fixed-function neuron core of the Taylor-network accelerator.
- Per frame it requests N_IN input samples over a shared input bus and accumulates the bias plus weighted inputs in fixed point.
- It applies a clamped third-order Taylor approximation of tanh, y = s − s³/3, and presents the signed result with a one-cycle valid strobe.
- Several cores share io_in and are started staggered by a top-level sequencer; a downstream mux selects the core whose out_en equals 1.

Parameters:
- N_IN, 3, number of inputs per frame (1..14).
- FRAC, 8, fractional bits of every fixed-point quantity (Q.8).
- W0..W13, 256 each, signed 19-bit input weights; only W0..W(N_IN−1) are used.
- BIAS, 0, signed 28-bit bias.
- C3, −85, signed 19-bit cubic coefficient (≈ −1/3 in Q.8).
- CLAMP, 256, magnitude limit applied to s before the polynomial (1.0).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous reset, active-low (0 = reset).
- io_in  in  19  signed input sample, driven by the environment according to req_in.
- io_out  out  28  signed result (Q.8).
- req_in  out  4  input request address: k+1 while requesting input k; 0 = no request.
- out_en  out  4  output strobe: 1 while io_out holds a new result; 0 otherwise.

Behaviour:
- Reset (rst = 0, asynchronous): io_out = 0, req_in = 0, out_en = 0, state = IDLE, accumulator = BIAS. All outputs are registered.
- IDLE: the first rising edge after rst = 1 moves to READ, k = 0, req_in = 1.
- READ k:
  - req_in = k+1 is visible for exactly one cycle.
  - At the edge ending that cycle, io_in is sampled and acc += (Wk·io_in) >>> FRAC, using an arithmetic (floor) shift.
  - The accumulator is at least 40 bits wide so it never wraps.
  - If k < N_IN−1: k+1, req_in = k+2. Otherwise req_in = 0 and the state goes to CLAMP.
- CLAMP: s = min(max(acc, −CLAMP), +CLAMP), held in a 28-bit register.
- SQ: s2 = (s·s) >>> FRAC.
- CUBE: s3 = (s2·s) >>> FRAC.
- OUT:
  - io_out = s + ((C3·s3) >>> FRAC), sign-extended to 28 bits. out_en = 1 for this single cycle.
  - Next edge: out_en = 0, acc = BIAS, k = 0, req_in = 1, state = READ.
- Timing for N_IN = 3:
  - The first out_en = 1 is visible after the 7th rising edge following reset release.
  - Frame period is N_IN+4 = 7 cycles, repeating indefinitely.
- io_out holds its last value between strobes. out_en takes only the values 0 and 1.
- Products are computed at full precision (19×19, 28×28) before shifting; no intermediate saturation except CLAMP.
- Output range is bounded by ±(CLAMP + |C3·CLAMP³|/2^(3·FRAC)) and cannot overflow 28 bits.
- Reset asserted mid-frame: the partial accumulation is discarded and outputs clear immediately without waiting for a clock. After release, the core restarts from IDLE.
- io_in is ignored in every state except READ.
- A multi-cycle multiplier is permitted only if the 7-cycle frame period is preserved.

Test Plan:
- Reset/startup: hold rst = 0 for 3 cycles → io_out = 0, req_in = 0, out_en = 0. Release → req_in sequence 1, 2, 3, then 0 on consecutive cycles; out_en = 1 after the 7th edge; period 7.
- Small signal: defaults, io_in = 64, 64, 0 for requests 1, 2, 3 → s = 128, s2 = 64, s3 = 32, io_out = 128 − 11 = 117 with out_en = 1.
- Positive clamp: io_in = 256, 256, 256 → acc = 768, clamped to 256 → io_out = 171.
- Negative clamp and symmetry: io_in = −256, −256, −256 → io_out = −171.
- Zero and bias: io_in all 0 → io_out = 0. Same with BIAS = 128 → io_out = 117.
- Mid-frame reset: assert rst = 0 while req_in = 2 → outputs 0 with no clock edge needed. After release, the full 7-cycle frame repeats and the result depends only on the new samples.
